// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: default widths, control-op
// encodings, FSM state encoding and the control-op decoder.
package fetch_pkg;

    localparam int DEF_ADDR_W      = 11;
    localparam int DEF_INST_W      = 14;
    localparam int DEF_STACK_DEPTH = 8;

    localparam logic [2:0]  OP_GOTO     = 3'b101;
    localparam logic [2:0]  OP_CALL     = 3'b100;
    localparam logic [3:0]  OP_RETLW    = 4'b1101;
    localparam logic [13:0] INST_RETURN = 14'h0008;
    localparam logic [13:0] INST_SLEEP  = 14'h0063;
    localparam logic [13:0] INST_NOP    = 14'h0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } fetch_state_t;

    typedef enum logic [2:0] {
        CTL_NONE  = 3'd0,
        CTL_GOTO  = 3'd1,
        CTL_CALL  = 3'd2,
        CTL_RET   = 3'd3,
        CTL_SLEEP = 3'd4
    } ctl_op_t;

    // RETLW is treated as a plain return here; its literal belongs to the datapath.
    function automatic ctl_op_t decode_ctl(input logic [13:0] inst);
        if (inst[13:11] == OP_GOTO)
            return CTL_GOTO;
        else if (inst[13:11] == OP_CALL)
            return CTL_CALL;
        else if (inst[13:10] == OP_RETLW || inst == INST_RETURN)
            return CTL_RET;
        else if (inst == INST_SLEEP)
            return CTL_SLEEP;
        else
            return CTL_NONE;
    endfunction

endpackage

// File: rtl/pc_stack.sv
// Circular hardware return stack. Overflow overwrites the oldest entry,
// underflow reads the wrapped entry; both leave sticky flags.
module pc_stack
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] pop_data,
    output logic [3:0]        depth,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top;     // next free slot
    logic [PTR_W-1:0]  top_m1;
    logic              full;
    logic              empty;

    assign top_m1   = top - PTR_W'(1);
    assign pop_data = mem[top_m1];
    assign full     = (depth == 4'(DEPTH));
    assign empty    = (depth == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top   <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            top <= top + PTR_W'(1);
            if (full)
                ovf <= 1'b1;
            else
                depth <= depth + 4'd1;
        end else if (pop) begin
            top <= top_m1;
            if (empty)
                unf <= 1'b1;
            else
                depth <= depth - 4'd1;
        end
    end

    // Contents are intentionally not reset; only the pointer and count are.
    always_ff @(posedge clk) begin
        if (push)
            mem[top] <= push_data;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-flow controller: owns the PC and return stack, fetches one ROM word
// per cycle into ir and resolves GOTO/CALL/RETURN/RETLW/SLEEP locally.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INST_W      = DEF_INST_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    input  logic              hold,
    input  logic              skip,
    input  logic              wake,
    output logic [INST_W-1:0] ir,
    output logic              ir_valid,
    output logic              sleeping,
    output logic [3:0]        stack_depth,
    output logic              stack_ovf,
    output logic              stack_unf
);

    // ir_valid=1 means ir executes in this cycle unless hold=1, in which case
    // everything (including ir and ir_valid) is held for the next cycle.
    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [INST_W-1:0] ir_n;
    logic              valid_n;
    logic              push, pop;
    logic [ADDR_W-1:0] pop_data;
    ctl_op_t           ctl;

    assign rom_addr = pc;
    assign sleeping = (state == ST_SLEEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            pc       <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        valid_n = ir_valid;
        push    = 1'b0;
        pop     = 1'b0;
        ctl     = ir_valid ? decode_ctl(ir) : CTL_NONE;
        case (state)
            ST_RUN: begin
                if (!hold) begin
                    // Control ops ignore skip; the bubble they create already squashes.
                    case (ctl)
                        CTL_GOTO: begin
                            pc_n    = ir[ADDR_W-1:0];
                            ir_n    = INST_NOP;
                            valid_n = 1'b0;
                        end
                        CTL_CALL: begin
                            push    = 1'b1;
                            pc_n    = ir[ADDR_W-1:0];
                            ir_n    = INST_NOP;
                            valid_n = 1'b0;
                        end
                        CTL_RET: begin
                            pop     = 1'b1;
                            pc_n    = pop_data;
                            ir_n    = INST_NOP;
                            valid_n = 1'b0;
                        end
                        CTL_SLEEP: begin
                            state_n = ST_SLEEP;
                            ir_n    = INST_NOP;
                            valid_n = 1'b0;
                        end
                        default: begin
                            ir_n    = rom_data;
                            pc_n    = pc + ADDR_W'(1);
                            valid_n = ~(ir_valid & skip);
                        end
                    endcase
                end
            end
            ST_SLEEP: begin
                if (!hold && wake)
                    state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    pc_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .pop_data  (pop_data),
        .depth     (stack_depth),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

endmodule
